// File: rtl/task_input_feeder_if.sv
// task_input_feeder_if: host-side AXI-Stream word channel feeding the task input unpacker.
interface task_input_feeder_if #(
    parameter int IN_WIDTH = 32
);
    logic [IN_WIDTH-1:0] tdata;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    modport master(output tdata, tvalid, tlast, input tready);
    modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/task_input_feeder.sv
// task_input_feeder: unpacks host words LSB-byte-first into a self-paced task byte stream.
// Defining TASK_INPUT_FEEDER_STATS_EN adds saturating o_bytes_sent / o_packets_sent counters.
module task_input_feeder #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int SIZE_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [SIZE_WIDTH-1:0] i_packet_size_in_bytes,
    task_input_feeder_if.slave    s_axis,
    output logic [OUT_WIDTH-1:0]  o_data,
    output logic                  o_valid,
    output logic                  o_first,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_trunc
`ifdef TASK_INPUT_FEEDER_STATS_EN
    ,
    output logic [SIZE_WIDTH-1:0] o_bytes_sent,
    output logic [15:0]           o_packets_sent
`endif
);
    localparam int LANES = IN_WIDTH / OUT_WIDTH;
    localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_DRAIN} state_t;

    state_t                state, state_n;
    logic [SIZE_WIDTH-1:0] size_q, cnt_q;
    logic [IN_WIDTH-1:0]   buf_q;
    logic                  buf_last_q;
    logic [LW-1:0]         lane_q;
    logic [OUT_WIDTH-1:0]  data_q;
    logic                  emit, hs, start_ok, size_end, last_lane, tl_end;

    assign emit      = state == S_EMIT;
    assign start_ok  = i_start && i_packet_size_in_bytes != '0;
    assign size_end  = cnt_q == size_q - SIZE_WIDTH'(1);
    assign last_lane = lane_q == LW'(LANES - 1);
    assign tl_end    = last_lane && buf_last_q;
    // Prefetch on the final lane keeps back-to-back host words bubble-free.
    assign s_axis.tready = state == S_WAIT || state == S_DRAIN ||
                           (emit && last_lane && !size_end && !buf_last_q);
    assign hs = s_axis.tvalid && s_axis.tready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = start_ok ? S_WAIT : S_IDLE;
            S_WAIT:  state_n = hs ? S_EMIT : S_WAIT;
            S_EMIT:  state_n = size_end ? (buf_last_q ? S_IDLE : S_DRAIN) :
                               tl_end ? S_IDLE :
                               (last_lane && !hs) ? S_WAIT : S_EMIT;
            S_DRAIN: state_n = (hs && s_axis.tlast) ? S_IDLE : S_DRAIN;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        o_valid = emit;
        o_first = emit && cnt_q == '0;
        o_last  = emit && (size_end || tl_end);
        o_trunc = emit && tl_end && !size_end;
        o_data  = emit ? buf_q[lane_q*OUT_WIDTH +: OUT_WIDTH] : data_q;
        o_busy  = state != S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            size_q     <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            buf_last_q <= 1'b0;
            lane_q     <= '0;
            data_q     <= '0;
        end else begin
            if (state == S_IDLE && start_ok) begin
                size_q <= i_packet_size_in_bytes;
                cnt_q  <= '0;
            end
            if (hs && state != S_DRAIN) begin
                buf_q      <= s_axis.tdata;
                buf_last_q <= s_axis.tlast;
                lane_q     <= '0;
            end else if (emit) begin
                lane_q <= lane_q + 1'b1;
            end
            if (emit) begin
                cnt_q  <= cnt_q + 1'b1;
                data_q <= o_data;
            end
        end
    end

`ifdef TASK_INPUT_FEEDER_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_bytes_sent   <= '0;
            o_packets_sent <= '0;
        end else begin
            if (o_valid && !(&o_bytes_sent))
                o_bytes_sent <= o_bytes_sent + 1'b1;
            if (o_last && !(&o_packets_sent))
                o_packets_sent <= o_packets_sent + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_task_input_feeder.sv
// tb_task_input_feeder: randomized + directed packets; a packet-level model fills a scoreboard
// that a negedge monitor drains against the DUT byte stream.
module tb_task_input_feeder;
    typedef struct {
        logic [7:0] d;
        bit         f, l, t, c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] size_in = '0;
    logic [7:0]  o_data;
    logic        o_valid, o_first, o_last, o_busy, o_trunc;
`ifdef TASK_INPUT_FEEDER_STATS_EN
    logic [31:0] o_bytes_sent;
    logic [15:0] o_packets_sent;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [31:0] wq[$];
    exp_t        cur;
    bit          rst_at_edge = 1'b0;
    bit          prev_valid = 1'b0;
    logic [7:0]  last_data = '0;

    task_input_feeder_if #(.IN_WIDTH(32)) ax();

    task_input_feeder dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_packet_size_in_bytes(size_in),
        .s_axis(ax),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_first(o_first),
        .o_last(o_last),
        .o_busy(o_busy),
        .o_trunc(o_trunc)
`ifdef TASK_INPUT_FEEDER_STATS_EN
        ,
        .o_bytes_sent(o_bytes_sent),
        .o_packets_sent(o_packets_sent)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) rst_at_edge <= !rst_n;

    always @(negedge clk) begin
        if (rst_at_edge) begin
            chk("reset_outputs", {o_data, o_valid, o_first, o_last, o_trunc, o_busy}, '0);
            last_data = '0;
            prev_valid = 1'b0;
        end else if (o_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", o_valid, 1'b0);
            end else begin
                cur = sb.pop_front();
                chk("data", o_data, cur.d);
                chk("first", o_first, cur.f);
                chk("last", o_last, cur.l);
                chk("trunc", o_trunc, cur.t);
                if (cur.c) chk("no_bubble", prev_valid, 1'b1);
            end
            last_data = o_data;
            prev_valid = 1'b1;
        end else begin
            chk("idle_flags", {o_first, o_last, o_trunc}, '0);
            chk("data_hold", o_data, last_data);
            prev_valid = 1'b0;
        end
    end

    task automatic handshake();
        bit ok;
        int k;
        k = 0;
        do begin
            @(negedge clk);
            ok = ax.tready;
            @(posedge clk);
            #1;
            k++;
        end while (!ok && k < 100);
        if (!ok) chk("tready_timeout", ax.tready, 1'b1);
    endtask

    // Expected stream: bytes LSB-first, cut at min(size, 4*words); trunc when host ran short.
    task automatic run_pkt(input int size, input int stall, input bit restart);
        int nb, n, k;
        exp_t e;
        logic [31:0] w;
        nb = wq.size() * 4;
        n = size < nb ? size : nb;
        for (int i = 0; i < n; i++) begin
            w = wq[i/4];
            e.d = w[(i%4)*8 +: 8];
            e.f = i == 0;
            e.l = i == n - 1;
            e.t = (i == n - 1) && (nb < size);
            e.c = (stall == 0) && (i > 0);
            sb.push_back(e);
        end
        start = 1'b1;
        size_in = size;
        tick();
        start = 1'b0;
        for (int j = 0; j < wq.size(); j++) begin
            ax.tdata = wq[j];
            ax.tlast = j == wq.size() - 1;
            ax.tvalid = 1'b1;
            handshake();
            if (j == 0) begin
                @(negedge clk);
                chk("latency_valid", o_valid, 1'b1);
            end
            ax.tvalid = 1'b0;
            ax.tlast = 1'b0;
            if (stall > 0 && j != wq.size() - 1) begin
                if (restart) begin
                    start = 1'b1;
                    size_in = 2;
                end
                tick();
                start = 1'b0;
                repeat (stall - 1) tick();
            end
        end
        k = 0;
        while (o_busy && k < 100) begin
            tick();
            k++;
        end
        chk("busy_done", o_busy, 1'b0);
        chk("sb_empty", sb.size(), 0);
        wq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int sz, nw, st;
        ax.tdata = '0;
        ax.tvalid = 1'b0;
        ax.tlast = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("idle_tready", ax.tready, 1'b0);
        start = 1'b1;
        size_in = 0;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("size0_ignored", o_busy, 1'b0);

        wq = '{32'h44332211, 32'h88776655};
        run_pkt(8, 0, 1'b0);
        wq = '{32'hDDCCBBAA, 32'h00000011, 32'hFFFFFFFF};
        run_pkt(5, 0, 1'b0);
        wq = '{32'h04030201};
        run_pkt(12, 0, 1'b0);
        wq = '{32'h000000A5};
        run_pkt(1, 0, 1'b0);
        wq = '{32'h14131211, 32'h18171615};
        run_pkt(8, 3, 1'b1);

        for (int p = 0; p < 25; p++) begin
            sz = $urandom_range(1, 14);
            nw = $urandom_range(1, 4);
            st = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            for (int j = 0; j < nw; j++) wq.push_back($urandom);
            run_pkt(sz, st, st > 0 && $urandom_range(0, 1) == 1);
        end

        // Mid-packet reset after two bytes: only those two bytes may appear.
        e.d = 8'h11; e.f = 1'b1; e.l = 1'b0; e.t = 1'b0; e.c = 1'b0;
        sb.push_back(e);
        e.d = 8'h22; e.f = 1'b0; e.c = 1'b1;
        sb.push_back(e);
        start = 1'b1;
        size_in = 8;
        tick();
        start = 1'b0;
        ax.tdata = 32'h44332211;
        ax.tvalid = 1'b1;
        handshake();
        ax.tvalid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_sb_empty", sb.size(), 0);
        tick();
        wq = '{32'h0A0B0C0D};
        run_pkt(4, 0, 1'b0);
`ifdef TASK_INPUT_FEEDER_STATS_EN
        chk("bytes_sent", o_bytes_sent, 4);
        chk("packets_sent", o_packets_sent, 1);
`endif
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
